// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: opcode field position, fetch FSM encoding, NOP word.
// Constants only; no latency or backpressure of its own.
package mips_pkg;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;

    typedef logic [1:0] fetch_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_skid_buf.sv
// Output register plus 1-entry hold buffer: in data appears at the output 1 edge later.
// Backpressure: a stalled live output diverts one arriving word into the hold buffer.
module if_skid_buf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld_i,
    input  logic [31:0] in_dat_i,
    input  logic [31:0] in_pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        hold_vld_o,
    output logic        to_hold_o,
    output logic        consume_o
);

    logic [31:0] out_dat_q, out_dat_d, out_pc_q, out_pc_d;
    logic [31:0] hold_dat_q, hold_dat_d, hold_pc_q, hold_pc_d;
    logic        out_vld_q, out_vld_d, hold_vld_q, hold_vld_d;
    logic        take;

    assign consume_o  = out_vld_q & ~stall_i;
    assign take       = ~out_vld_q | consume_o;
    assign to_hold_o  = in_vld_i & (~take | hold_vld_q);
    assign instr_o    = out_dat_q;
    assign pc_o       = out_pc_q;
    assign valid_o    = out_vld_q;
    assign hold_vld_o = hold_vld_q;

    always_comb begin
        out_dat_d  = out_dat_q;
        out_pc_d   = out_pc_q;
        out_vld_d  = out_vld_q;
        hold_dat_d = hold_dat_q;
        hold_pc_d  = hold_pc_q;
        hold_vld_d = hold_vld_q;
        if (flush_i) begin
            out_vld_d  = 1'b0;
            hold_vld_d = 1'b0;
        end else if (take) begin
            // The held word is older than anything arriving now, so it goes out first.
            if (hold_vld_q) begin
                out_dat_d  = hold_dat_q;
                out_pc_d   = hold_pc_q;
                out_vld_d  = 1'b1;
                hold_dat_d = in_dat_i;
                hold_pc_d  = in_pc_i;
                hold_vld_d = in_vld_i;
            end else if (in_vld_i) begin
                out_dat_d  = in_dat_i;
                out_pc_d   = in_pc_i;
                out_vld_d  = 1'b1;
            end else begin
                out_vld_d  = 1'b0;
            end
        end else if (in_vld_i) begin
            hold_dat_d = in_dat_i;
            hold_pc_d  = in_pc_i;
            hold_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_dat_q  <= NOP_WORD;
            out_pc_q   <= 32'h0;
            out_vld_q  <= 1'b0;
            hold_dat_q <= NOP_WORD;
            hold_pc_q  <= 32'h0;
            hold_vld_q <= 1'b0;
        end else begin
            out_dat_q  <= out_dat_d;
            out_pc_q   <= out_pc_d;
            out_vld_q  <= out_vld_d;
            hold_dat_q <= hold_dat_d;
            hold_pc_q  <= hold_pc_d;
            hold_vld_q <= hold_vld_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM with redirect/drain; ack to valid is 1 edge, 1 instr/cycle sustained.
// Stall backs up into a 1-entry hold buffer, then requests pause. IF_FETCH_CNT_EN adds fetch_cnt.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] pc_out,
    output logic        valid
`ifdef IF_FETCH_CNT_EN
   ,output logic [31:0] fetch_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  addr_q, addr_d, tgt_q, tgt_d;
    logic [31:0]  rpc;
    logic         in_vld, hold_vld, to_hold, consume;

    assign rpc       = redirect_pc & ~32'h3;
    assign in_vld    = (state_q == ST_REQ) & imem_ack & ~redirect;
    assign imem_req  = (state_q == ST_REQ) | (state_q == ST_DRAIN);
    assign imem_addr = addr_q;
    assign op        = instr[OP_MSB:OP_LSB];

    if_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_vld_i   (in_vld),
        .in_dat_i   (imem_rdata),
        .in_pc_i    (addr_q),
        .stall_i    (stall),
        .flush_i    (redirect),
        .instr_o    (instr),
        .pc_o       (pc_out),
        .valid_o    (valid),
        .hold_vld_o (hold_vld),
        .to_hold_o  (to_hold),
        .consume_o  (consume)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tgt_d   = tgt_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    addr_d  = rpc;
                    state_d = ST_REQ;
                end else if (!hold_vld || consume) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    // Address must stay put while the old request is still open.
                    if (imem_ack) begin
                        addr_d  = rpc;
                    end else begin
                        tgt_d   = rpc;
                        state_d = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    addr_d = addr_q + 32'd4;
                    if (to_hold) state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    if (imem_ack) begin
                        addr_d  = rpc;
                        state_d = ST_REQ;
                    end else begin
                        tgt_d   = rpc;
                    end
                end else if (imem_ack) begin
                    addr_d  = tgt_q;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= RESET_PC;
            tgt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
        end
    end

`ifdef IF_FETCH_CNT_EN
    logic [31:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 32'h0;
        else if (consume) cnt_q <= cnt_q + 32'd1;
    end
    assign fetch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc_out;
    logic        valid;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    int errors = 0;
    int checks = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .op          (op),
        .pc_out      (pc_out),
        .valid       (valid)
`ifdef IF_FETCH_CNT_EN
       ,.fetch_cnt   (fetch_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    // Drive one cycle of inputs at a negedge, then move to the next negedge.
    task automatic step(input logic a, input logic s, input logic r, input logic [31:0] rp);
        imem_ack    = a & imem_req;
        imem_rdata  = mem_word(imem_addr);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (instr !== 32'h0 || op !== 6'h0 || pc_out !== 32'h0) begin
            errors++; $display("FAIL reset_out got instr=%h op=%h pc=%h exp all 0", instr, op, pc_out); end
`ifdef IF_FETCH_CNT_EN
        checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
                errors++; $display("FAIL stream_addr%0d got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, 4 * i); end
            step(1, 0, 0, 0);
            checks++; if (valid !== 1'b1 || pc_out !== 32'(4 * i) || instr !== mem_word(32'(4 * i))) begin
                errors++; $display("FAIL stream_out%0d got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                                   i, valid, pc_out, instr, 4 * i, mem_word(32'(4 * i))); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        checks++; if (imem_req !== 1'b0 || valid !== 1'b1 || pc_out !== 32'h4) begin
            errors++; $display("FAIL stall_hold got req=%b v=%b pc=%h exp req=0 v=1 pc=4", imem_req, valid, pc_out); end
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        checks++; if (imem_req !== 1'b0 || pc_out !== 32'h4) begin
            errors++; $display("FAIL stall_wait got req=%b pc=%h exp req=0 pc=4", imem_req, pc_out); end
        step(0, 0, 0, 0);
        checks++; if (valid !== 1'b1 || pc_out !== 32'h8 || instr !== mem_word(32'h8) || op !== mem_word(32'h8) >> 26) begin
            errors++; $display("FAIL stall_release got v=%b pc=%h instr=%h op=%h exp pc=8 instr=%h", valid, pc_out, instr, op, mem_word(32'h8)); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            errors++; $display("FAIL stall_nextreq got req=%b addr=%h exp req=1 addr=c", imem_req, imem_addr); end
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(0, 0, 1, 32'h100);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || valid !== 1'b0) begin
            errors++; $display("FAIL drain_hold got req=%b addr=%h v=%b exp req=1 addr=10 v=0", imem_req, imem_addr, valid); end
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++; if (imem_addr !== 32'h100 || valid !== 1'b0) begin
            errors++; $display("FAIL drain_target got addr=%h v=%b exp addr=100 v=0", imem_addr, valid); end
        step(1, 0, 0, 0);
        checks++; if (valid !== 1'b1 || pc_out !== 32'h100 || instr !== mem_word(32'h100)) begin
            errors++; $display("FAIL drain_return got v=%b pc=%h exp v=1 pc=100", valid, pc_out); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 32'h203);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || valid !== 1'b0) begin
            errors++; $display("FAIL redir_ack got req=%b addr=%h v=%b exp req=1 addr=200 v=0", imem_req, imem_addr, valid); end
        step(1, 0, 0, 0);
        checks++; if (valid !== 1'b1 || pc_out !== 32'h200) begin
            errors++; $display("FAIL redir_ack_out got v=%b pc=%h exp v=1 pc=200", valid, pc_out); end
    endtask

    task automatic test_wrap();
        do_reset();
        step(0, 0, 1, 32'hFFFF_FFF8);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++; if (pc_out !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap got pc=%h addr=%h exp pc=fffffffc addr=0", pc_out, imem_addr); end
        step(1, 0, 0, 0);
        checks++; if (valid !== 1'b1 || pc_out !== 32'h0 || instr !== mem_word(32'h0)) begin
            errors++; $display("FAIL wrap_out got v=%b pc=%h exp v=1 pc=0", valid, pc_out); end
    endtask

    task automatic test_reset_drain();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(0, 0, 1, 32'h300);
        imem_ack = 1'b0; redirect = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || valid !== 1'b0 || instr !== 32'h0 || pc_out !== 32'h0 || op !== 6'h0) begin
            errors++; $display("FAIL rstdrain_outs got req=%b addr=%h v=%b instr=%h pc=%h exp all reset", imem_req, imem_addr, valid, instr, pc_out); end
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0) begin
            errors++; $display("FAIL rstdrain_restart got req=%b addr=%h v=%b exp req=1 addr=0 v=0", imem_req, imem_addr, valid); end
        step(1, 0, 0, 0);
        checks++; if (valid !== 1'b1 || pc_out !== 32'h0 || instr !== mem_word(32'h0)) begin
            errors++; $display("FAIL rstdrain_first got v=%b pc=%h instr=%h exp v=1 pc=0 instr=%h", valid, pc_out, instr, mem_word(32'h0)); end
    endtask

`ifdef IF_FETCH_CNT_EN
    task automatic test_fetch_cnt();
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 1, 32'h40);
        checks++; if (fetch_cnt !== 32'd5 || valid !== 1'b0) begin
            errors++; $display("FAIL fetch_cnt got=%0d v=%b exp=5 v=0", fetch_cnt, valid); end
    endtask
`endif

    // Reference: consumed instructions form the sequential program order,
    // restarting at each redirect target; the request address never moves while open.
    task automatic test_random();
        logic [31:0] exp_pc, prev_addr, rp;
        logic        pending, a, s, r;
        int          consumed;
        do_reset();
        exp_pc = 32'h0; pending = 1'b0; prev_addr = 32'h0; consumed = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            a = ($urandom_range(0, 9) < 6);
            s = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 19) == 0);
            rp = $urandom;
            if (pending) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    errors++; $display("FAIL rand_stable cyc=%0d got req=%b addr=%h exp req=1 addr=%h", cyc, imem_req, imem_addr, prev_addr); end
            end
            if (imem_req && imem_addr[1:0] != 2'b00) begin
                checks++; errors++; $display("FAIL rand_align cyc=%0d got addr=%h exp low bits 0", cyc, imem_addr);
            end
            if (valid && !s) begin
                checks++; if (pc_out !== exp_pc || instr !== mem_word(exp_pc) || op !== mem_word(exp_pc) >> 26) begin
                    errors++; $display("FAIL rand_order cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h", cyc, pc_out, instr, exp_pc, mem_word(exp_pc)); end
                exp_pc = pc_out + 32'd4;
                consumed++;
            end
            if (r) exp_pc = rp & ~32'h3;
            pending   = imem_req & ~a;
            prev_addr = imem_addr;
            step(a, s, r, rp);
        end
        checks++; if (consumed < 200) begin
            errors++; $display("FAIL rand_progress got=%0d consumed exp>=200", consumed); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_drain();
        test_redirect_ack();
        test_wrap();
        test_reset_drain();
`ifdef IF_FETCH_CNT_EN
        test_fetch_cnt();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, shall set the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state shall update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  word-aligned fetch address; stable while imem_req=1 until imem_ack.
REQ-006 imem_ack  input  1  one-cycle data-valid pulse, meaningful only while imem_req=1.
REQ-007 imem_rdata  input  32  instruction word, valid in the imem_ack cycle.
REQ-008 stall  input  1  downstream hold; the output instruction is consumed in a cycle with valid=1 and stall=0.
REQ-009 redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 redirect_pc  input  32  target address; bits [1:0] shall be forced to 0.
REQ-011 instr  output  32  registered fetched instruction.
REQ-012 op  output  6  instr[31:26], direct feed to the control decoder's op input.
REQ-013 pc_out  output  32  address of instr.
REQ-014 valid  output  1  instr/op/pc_out hold a live instruction.

Function
REQ-015 One request shall be outstanding at most; a transfer occurs in a cycle with imem_req=1 and imem_ack=1.
REQ-016 States IDLE (imem_req=0), REQ (imem_req=1, data kept), DRAIN (imem_req=1, data discarded).
REQ-017 IDLE->REQ when the hold buffer is empty, or is emptied into the output register in the same cycle.
REQ-018 REQ, ack, no redirect: data goes to the output register if valid=0 or stall=0, otherwise to the 1-entry hold buffer; imem_addr += 4.
REQ-019 REQ stays REQ after an ack into the output register, and goes to IDLE after an ack into the hold buffer.
REQ-020 On consumption, the output register shall load from the hold buffer first, then from incoming data, otherwise valid shall become 0.
REQ-021 Redirect shall take priority over stall and ack, and shall clear valid and the hold buffer in the same edge.
REQ-022 Redirect in REQ with ack in the same cycle: discard the data, imem_addr<=redirect_pc, stay in REQ.
REQ-023 Redirect in REQ without ack: latch the target, go to DRAIN.
REQ-024 Redirect in DRAIN: overwrite the latched target.
REQ-025 Redirect in IDLE: imem_addr<=redirect_pc, go to REQ.
REQ-026 DRAIN, ack: discard the data, imem_addr<=latched target, go to REQ.
REQ-027 Address arithmetic shall be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-028 Steady-state throughput with single-cycle ack and stall=0 shall be 1 instruction/cycle; latency from ack to valid shall be 1 edge.

Reset
REQ-029 On rst=1: state IDLE, imem_req=0, imem_addr=RESET_PC, instr=0, op=0, pc_out=0, valid=0, hold buffer empty, latched target=0.
REQ-030 On the first edge after rst deasserts, the block shall enter REQ; mid-operation reset shall abandon any outstanding request, and a late ack shall be ignored.

Configuration
REQ-031 With IF_FETCH_CNT_EN defined: output fetch_cnt (32) shall count consumed instructions, reset to 0, wrap at 2^32, and be unaffected by redirect.
REQ-032 Without IF_FETCH_CNT_EN: no fetch_cnt port and no counter logic.

Structure
REQ-033 Shared package mips_pkg shall hold the opcode field position constants (31:26), the state encoding typedef, and the NOP word (32'h0).
REQ-034 The hold buffer plus output register shall be one sub-module, if_skid_buf; the FSM and address logic stay in fetch_unit.

Verification
REQ-035 Reset release, ack every cycle, stall=0: addresses 0,4,8 are fetched; pc_out 0,4,8 appear on consecutive cycles with valid=1.
REQ-036 stall=1 for 3 cycles while the ack for addr 8 arrives: the word lands in the hold buffer, state goes to IDLE, imem_req=0; after stall drops, instr(8) then a new request for 12.
REQ-037 Redirect to 32'h100 while a request for 0x10 is pending (ack delayed 2 cycles): DRAIN, data for 0x10 discarded, next imem_addr=0x100, valid=0 until it returns.
REQ-038 Redirect with redirect_pc=32'h203 while an ack arrives in the same cycle: data dropped, imem_addr=0x200 on the next cycle.
REQ-039 rst pulse while in DRAIN: all outputs return to reset values; the stale ack is ignored; the fetch restarts at RESET_PC.
REQ-040 With IF_FETCH_CNT_EN: 5 consumed, 2 flushed instructions -> fetch_cnt=5.
